// File: rtl/click_pkg.sv
// Shared definitions for the click front-end: FSM state encoding and default timing.
package click_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HELD1     = 3'd1,
    LONG_WAIT = 3'd2,
    GAP       = 3'd3,
    HELD2     = 3'd4
  } state_t;

  localparam int DEF_DB_CYCLES   = 4;
  localparam int DEF_DBL_WIN     = 16;
  localparam int DEF_LONG_CYCLES = 32;
  localparam int DEF_CNT_W       = 10;

  function automatic int tmr_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/click_debounce.sv
// Two-flop synchroniser plus stable-sample debouncer for the raw click pin.
// rise/fall flag the edge on which y is about to change, so the FSM reacts in step with y.
module click_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic click,
  output logic y,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES) + 1;

  logic          s1, s2;
  logic [CW-1:0] cnt;
  logic          flip;

  assign flip = (s2 != y) && (cnt == CW'(DB_CYCLES - 1));
  assign rise = flip & ~y;
  assign fall = flip & y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      y   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= click;
      s2 <= s1;
      if (s2 == y) begin
        cnt <= '0;
      end else if (flip) begin
        cnt <= '0;
        y   <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/click_seq_ctrl.sv
// Click gesture classifier: debounced level in, SINGLE/DOUBLE/LONG pulses and a
// wrapping gesture count out.
module click_seq_ctrl
  import click_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int DBL_WIN     = DEF_DBL_WIN,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             click,
  input  logic             en,
  output logic             y,
  output logic             single_p,
  output logic             double_p,
  output logic             long_p,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam int TW = tmr_width(DBL_WIN, LONG_CYCLES);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          rise, fall;
  logic          single_nx, double_nx, long_nx;
  logic          win_end, long_end;

  click_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
    .clk   (clk),
    .rst   (rst),
    .click (click),
    .y     (y),
    .rise  (rise),
    .fall  (fall)
  );

  assign win_end  = (timer == TW'(DBL_WIN - 1));
  assign long_end = (timer == TW'(LONG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      busy     <= 1'b0;
      single_p <= 1'b0;
      double_p <= 1'b0;
      long_p   <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      busy     <= (state_nx != IDLE);
      single_p <= single_nx;
      double_p <= double_nx;
      long_p   <= long_nx;
      if (single_p | double_p | long_p) count <= count + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:      if (rise) state_nx = HELD1;
        HELD1:     if (fall) state_nx = GAP;
                   else if (long_end) state_nx = LONG_WAIT;
        LONG_WAIT: if (fall) state_nx = IDLE;
        // window expiry beats a coincident second press
        GAP:       if (win_end) state_nx = IDLE;
                   else if (rise) state_nx = HELD2;
        HELD2:     if (fall) state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    single_nx = en && (state == GAP) && win_end;
    double_nx = en && (state == HELD2) && fall;
    long_nx   = en && (state == HELD1) && !fall && long_end;
    timer_nx  = timer;
    if (!en || (state_nx != state)) timer_nx = '0;
    else if (timer != '1)           timer_nx = timer + 1'b1;
  end

endmodule

// File: tb/tb_click_seq_ctrl.sv
// Scoreboard bench for click_seq_ctrl: gesture-level reference model feeds an event queue.
module tb_click_seq_ctrl;

  localparam int DB   = 4;
  localparam int WIN  = 16;
  localparam int LONG = 32;
  localparam int CW   = 10;

  logic          clk = 1'b0, rst = 1'b1, click = 1'b0, en = 1'b1;
  logic          y, single_p, double_p, long_p, busy;
  logic [CW-1:0] count;

  always #2 clk = ~clk;

  click_seq_ctrl #(.DB_CYCLES(DB), .DBL_WIN(WIN), .LONG_CYCLES(LONG), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .click(click), .en(en), .y(y),
    .single_p(single_p), .double_p(double_p), .long_p(long_p),
    .busy(busy), .count(count)
  );

  typedef struct { int kind; int cyc; } ev_t;   // kind: 0 single, 1 double, 2 long
  ev_t evq[$];

  int tests = 0, fails = 0;
  int cyc = 0;
  bit m_s1, m_s2, m_y, m_inc;
  int m_run, m_mode, m_t0, m_cnt;              // mode: 0 idle,1 first press,2 long held,3 gap,4 second press
  int seen[3] = '{0, 0, 0};
  int base[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic emit(input int k);
    evq.push_back('{kind: k, cyc: cyc});
    m_inc = 1'b1;
  endtask

  // Reference model: gesture rules expressed as durations since the last clean edge.
  always @(posedge clk) begin : model
    bit old, r, f;
    cyc++;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_y = 0; m_run = 0; m_mode = 0; m_cnt = 0; m_inc = 0;
      evq.delete();
    end else begin
      if (m_inc) m_cnt = (m_cnt + 1) % (1 << CW);
      m_inc = 0;
      old = m_s2; m_s2 = m_s1; m_s1 = click;
      r = 0; f = 0;
      if (old != m_y) begin
        m_run++;
        if (m_run == DB) begin
          m_y = old; m_run = 0; r = m_y; f = !m_y;
        end
      end else m_run = 0;
      if (!en) m_mode = 0;
      else case (m_mode)
        0: if (r) begin m_mode = 1; m_t0 = cyc; end
        1: if (f) begin m_mode = 3; m_t0 = cyc; end
           else if (cyc - m_t0 == LONG) begin emit(2); m_mode = 2; end
        2: if (f) m_mode = 0;
        3: if (cyc - m_t0 == WIN) begin emit(0); m_mode = 0; end
           else if (r) m_mode = 4;
        4: if (f) begin emit(1); m_mode = 0; end
        default: m_mode = 0;
      endcase
    end
  end

  always @(posedge clk) begin : monitor
    int k;
    ev_t e;
    #1;
    check("y", y, m_y);
    check("busy", busy, (m_mode != 0));
    check("count", count, m_cnt);
    check("onehot", ($countones({single_p, double_p, long_p}) <= 1), 1);
    if (single_p | double_p | long_p) begin
      k = double_p ? 1 : (long_p ? 2 : 0);
      seen[k]++;
      if (evq.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_pulse: got kind %0d expected none at cycle %0d", k, cyc);
      end else begin
        e = evq.pop_front();
        check("ev_kind", k, e.kind);
        check("ev_cycle", cyc, e.cyc);
      end
    end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
      e = evq.pop_front();
      tests++; fails++;
      $display("FAIL missed_pulse: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
    end
  end

  task automatic hold(input logic v, input int n);
    click = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    base = seen;
  endtask

  task automatic expect_ev(input string name, input int s, input int d, input int l);
    check({name, "_single"}, seen[0] - base[0], s);
    check({name, "_double"}, seen[1] - base[1], d);
    check({name, "_long"},   seen[2] - base[2], l);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; click = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      click = ~click;
    end
    check("rst_y", y, 0);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_pulses", {single_p, double_p, long_p}, 0);
    @(negedge clk);
    rst = 1'b0; click = 1'b0;
    hold(0, 5);

    mark(); hold(1, 10); hold(0, 40);
    expect_ev("t2", 1, 0, 0);
    check("t2_count", count, 1);

    mark(); hold(1, 8); hold(0, 6); hold(1, 8); hold(0, 30);
    expect_ev("t3", 0, 1, 0);
    check("t3_count", count, 2);

    mark(); hold(1, 60); hold(0, 30);
    expect_ev("t4", 0, 0, 1);
    check("t4_count", count, 3);

    mark(); hold(1, 1); hold(0, 5); hold(1, 3); hold(0, 10);
    expect_ev("t5", 0, 0, 0);
    check("t5_count", count, 3);

    mark(); hold(1, 10);
    en = 1'b0; hold(1, 5);
    check("t6_en_busy", busy, 0);
    en = 1'b1; hold(1, 5); hold(0, 40);
    expect_ev("t6_en", 0, 0, 0);
    check("t6_en_count", count, 3);

    mark(); hold(1, 10); hold(0, 10);
    rst = 1'b1; hold(0, 2);
    rst = 1'b0;
    check("t6_rst_count", count, 0);
    check("t6_rst_busy", busy, 0);
    hold(0, 40);
    expect_ev("t6_rst", 0, 0, 0);

    mark();
    repeat (1024) begin
      hold(1, 6); hold(0, 24);
    end
    expect_ev("wrap", 1024, 0, 0);
    check("wrap_count", count, 0);

    repeat (400) begin
      en = ($urandom_range(0, 9) != 0);
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 40));
    end
    en = 1'b1;
    hold(0, 80);
    check("drain_q", evq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
